// File: rtl/pipe_collision_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipe_collision_sequencer                                                    |
// | Snapshots the on-screen pipes once per frame, walks one shared collision    |
// | checker across them and tracks the READY/PLAYING/OVER game state.           |
// | Optional: PIPE_COLLISION_INVULN_EN masks hits for the first INVULN_FRAMES   |
// | scans after start.                                                          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pipe_collision_sequencer #(
    parameter int NUM_PIPES     = 4,
    parameter int IDX_W         = 2,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    frame_tick,
    input  logic [NUM_PIPES-1:0]    pipe_valid,
    input  logic [10*NUM_PIPES-1:0] pipe_x_all,
    input  logic [10*NUM_PIPES-1:0] pipe_y_top_all,
    input  logic [10*NUM_PIPES-1:0] pipe_y_bot_all,
    output logic [9:0]              chk_pipe_x,
    output logic [9:0]              chk_pipe_y_top,
    output logic [9:0]              chk_pipe_y_bot,
    input  logic                    chk_collided,
    output logic [1:0]              game_state,
    output logic                    game_over,
    output logic [IDX_W-1:0]        hit_pipe,
    output logic                    scan_busy,
    output logic                    scan_done,
    output logic                    frame_overrun,
    output logic                    invuln
);

    typedef enum logic [1:0] {
        ST_READY      = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_SCAN       = 2'd2,
        ST_OVER       = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_PIPES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_PIPES-1:0]   snap_valid_q, snap_valid_d;
    logic [9:0]             snap_x_q   [NUM_PIPES];
    logic [9:0]             snap_x_d   [NUM_PIPES];
    logic [9:0]             snap_top_q [NUM_PIPES];
    logic [9:0]             snap_top_d [NUM_PIPES];
    logic [9:0]             snap_bot_q [NUM_PIPES];
    logic [9:0]             snap_bot_d [NUM_PIPES];
    logic                   hit_found_q, hit_found_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic [IDX_W-1:0]       hit_pipe_q, hit_pipe_d;
    logic                   overrun_q, overrun_d;
    logic                   scan_done_q, scan_done_d;
    logic                   game_over_q, game_over_d;
    logic                   scan_busy_q, scan_busy_d;
    logic [1:0]             game_state_q, game_state_d;
    logic                   w_in_scan;
    logic                   w_masked;
    logic                   w_hit_now;

    assign w_in_scan = (state_q == ST_SCAN);
    assign w_hit_now = w_in_scan && snap_valid_q[idx_q] && chk_collided && !w_masked;

    // The checker sees only snapshot data, and idles at zero between scans.
    always_comb begin
        chk_pipe_x     = '0;
        chk_pipe_y_top = '0;
        chk_pipe_y_bot = '0;
        if (w_in_scan) begin
            chk_pipe_x     = snap_x_q[idx_q];
            chk_pipe_y_top = snap_top_q[idx_q];
            chk_pipe_y_bot = snap_bot_q[idx_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_valid_d = snap_valid_q;
        snap_x_d     = snap_x_q;
        snap_top_d   = snap_top_q;
        snap_bot_d   = snap_bot_q;
        hit_found_d  = hit_found_q;
        hit_idx_d    = hit_idx_q;
        hit_pipe_d   = hit_pipe_q;
        overrun_d    = overrun_q;
        scan_done_d  = 1'b0;
        case (state_q)
            ST_READY: begin
                if (start) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d      = ST_SCAN;
                    idx_d        = '0;
                    hit_found_d  = 1'b0;
                    snap_valid_d = pipe_valid;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        snap_x_d[i]   = pipe_x_all[10*i +: 10];
                        snap_top_d[i] = pipe_y_top_all[10*i +: 10];
                        snap_bot_d[i] = pipe_y_bot_all[10*i +: 10];
                    end
                end
            end
            ST_SCAN: begin
                if (frame_tick) overrun_d = 1'b1;
                // First hit wins; later hits in the same scan leave it alone.
                if (w_hit_now && !hit_found_q) begin
                    hit_found_d = 1'b1;
                    hit_idx_d   = idx_q;
                end
                if (idx_q == c_last_idx) begin
                    idx_d       = '0;
                    scan_done_d = 1'b1;
                    if (hit_found_q || w_hit_now) begin
                        state_d    = ST_OVER;
                        hit_pipe_d = hit_found_q ? hit_idx_q : idx_q;
                    end else begin
                        state_d = ST_WAIT_FRAME;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d    = ST_READY;
                    hit_pipe_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            default: state_d = ST_READY;
        endcase

        case (state_d)
            ST_READY:      game_state_d = 2'd0;
            ST_OVER:       game_state_d = 2'd2;
            default:       game_state_d = 2'd1;
        endcase
        game_over_d = (state_d == ST_OVER);
        scan_busy_d = (state_d == ST_SCAN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_READY;
            idx_q        <= '0;
            snap_valid_q <= '0;
            snap_x_q     <= '{default: '0};
            snap_top_q   <= '{default: '0};
            snap_bot_q   <= '{default: '0};
            hit_found_q  <= 1'b0;
            hit_idx_q    <= '0;
            hit_pipe_q   <= '0;
            overrun_q    <= 1'b0;
            scan_done_q  <= 1'b0;
            game_over_q  <= 1'b0;
            scan_busy_q  <= 1'b0;
            game_state_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_valid_q <= snap_valid_d;
            snap_x_q     <= snap_x_d;
            snap_top_q   <= snap_top_d;
            snap_bot_q   <= snap_bot_d;
            hit_found_q  <= hit_found_d;
            hit_idx_q    <= hit_idx_d;
            hit_pipe_q   <= hit_pipe_d;
            overrun_q    <= overrun_d;
            scan_done_q  <= scan_done_d;
            game_over_q  <= game_over_d;
            scan_busy_q  <= scan_busy_d;
            game_state_q <= game_state_d;
        end
    end

    assign game_state    = game_state_q;
    assign game_over     = game_over_q;
    assign hit_pipe      = hit_pipe_q;
    assign scan_busy     = scan_busy_q;
    assign scan_done     = scan_done_q;
    assign frame_overrun = overrun_q;

`ifdef PIPE_COLLISION_INVULN_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       invuln_q, invuln_d;

    // Counts completed scans since start, saturating at 255.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_READY && start) begin
            frame_cnt_d = '0;
        end else if (scan_done_d && frame_cnt_q != 8'hFF) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        invuln_d = (state_d == ST_WAIT_FRAME || state_d == ST_SCAN) &&
                   (int'({24'd0, frame_cnt_d}) < INVULN_FRAMES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            invuln_q    <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            invuln_q    <= invuln_d;
        end
    end

    assign w_masked = (int'({24'd0, frame_cnt_q}) < INVULN_FRAMES);
    assign invuln   = invuln_q;
`else
    logic w_unused_invuln_cfg;
    assign w_unused_invuln_cfg = (INVULN_FRAMES != 0);
    assign w_masked = 1'b0;
    assign invuln   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_collision_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pipe_collision_sequencer                                                 |
// | Vector table, directed corner sequences and random stimulus against a       |
// | frame-level reference model of the sequencer.                               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_pipe_collision_sequencer;

    localparam int N   = 4;
    localparam int INV = 2;
`ifdef PIPE_COLLISION_INVULN_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif
    localparam logic [9:0] c_bird_y = 10'd200;

    logic            clk;
    logic            reset, start, frame_tick;
    logic [N-1:0]    pipe_valid;
    logic [10*N-1:0] pipe_x_all, pipe_y_top_all, pipe_y_bot_all;
    logic [9:0]      chk_pipe_x, chk_pipe_y_top, chk_pipe_y_bot;
    logic            chk_collided;
    logic [1:0]      game_state;
    logic            game_over;
    logic [1:0]      hit_pipe;
    logic            scan_busy, scan_done, frame_overrun, invuln;

    int checks = 0;
    int errors = 0;

    pipe_collision_sequencer #(
        .NUM_PIPES     (N),
        .IDX_W         (2),
        .INVULN_FRAMES (INV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .frame_tick     (frame_tick),
        .pipe_valid     (pipe_valid),
        .pipe_x_all     (pipe_x_all),
        .pipe_y_top_all (pipe_y_top_all),
        .pipe_y_bot_all (pipe_y_bot_all),
        .chk_pipe_x     (chk_pipe_x),
        .chk_pipe_y_top (chk_pipe_y_top),
        .chk_pipe_y_bot (chk_pipe_y_bot),
        .chk_collided   (chk_collided),
        .game_state     (game_state),
        .game_over      (game_over),
        .hit_pipe       (hit_pipe),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .frame_overrun  (frame_overrun),
        .invuln         (invuln)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in collision unit: bird at fixed y, x window 100..140.
    function automatic logic collide(input logic [9:0] x, input logic [9:0] t, input logic [9:0] b);
        return (x >= 10'd100) && (x <= 10'd140) && ((c_bird_y <= t) || (c_bird_y >= b));
    endfunction

    assign chk_collided = collide(chk_pipe_x, chk_pipe_y_top, chk_pipe_y_bot);

    // Reference model: game phase plus a countdown over a precomputed scan.
    int         m_phase;   // 0 READY, 1 PLAYING, 2 OVER
    int         m_left;    // scan cycles still to present, 0 when not scanning
    int         m_first;   // lowest hitting pipe of the current scan, -1 if none
    int         m_hit;
    int         m_frames;
    bit         m_ovr;
    bit         m_done;
    logic [9:0] m_x [N];
    logic [9:0] m_t [N];
    logic [9:0] m_b [N];

    task automatic model_step();
        bit masked;
        m_done = 1'b0;
        if (reset) begin
            m_phase = 0; m_left = 0; m_hit = 0; m_ovr = 1'b0; m_frames = 0; m_first = -1;
        end else if (m_left > 0) begin
            if (frame_tick) m_ovr = 1'b1;
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                if (m_frames < 255) m_frames++;
                if (m_first >= 0) begin
                    m_phase = 2;
                    m_hit   = m_first;
                end
            end
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_frames = 0; end
                1: if (frame_tick) begin
                    masked  = INV_EN && (m_frames < INV);
                    m_first = -1;
                    for (int i = N - 1; i >= 0; i--) begin
                        m_x[i] = pipe_x_all[10*i +: 10];
                        m_t[i] = pipe_y_top_all[10*i +: 10];
                        m_b[i] = pipe_y_bot_all[10*i +: 10];
                        if (pipe_valid[i] && !masked && collide(m_x[i], m_t[i], m_b[i])) m_first = i;
                    end
                    m_left = N;
                end
                default: if (start) begin m_phase = 0; m_hit = 0; m_ovr = 1'b0; end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [9:0] ex, et, eb;
        ex = '0; et = '0; eb = '0;
        if (m_left > 0) begin
            ex = m_x[N - m_left]; et = m_t[N - m_left]; eb = m_b[N - m_left];
        end
        check("m_game_state", {30'd0, game_state}, m_phase);
        check("m_game_over", {31'd0, game_over}, {31'd0, m_phase == 2});
        check("m_hit_pipe", {30'd0, hit_pipe}, m_hit);
        check("m_scan_busy", {31'd0, scan_busy}, {31'd0, m_left > 0});
        check("m_scan_done", {31'd0, scan_done}, {31'd0, m_done});
        check("m_overrun", {31'd0, frame_overrun}, {31'd0, m_ovr});
        check("m_invuln", {31'd0, invuln}, {31'd0, INV_EN && m_phase == 1 && m_frames < INV});
        check("m_chk_x", {22'd0, chk_pipe_x}, {22'd0, ex});
        check("m_chk_top", {22'd0, chk_pipe_y_top}, {22'd0, et});
        check("m_chk_bot", {22'd0, chk_pipe_y_bot}, {22'd0, eb});
    endtask

    task automatic step(input logic r, input logic s, input logic t);
        reset = r; start = s; frame_tick = t;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    // Fixed pipe layouts: gaps all miss the bird, so x alone decides a hit.
    task automatic set_pat(input int p);
        logic [9:0] xs [N];
        case (p)
            1:       xs = '{10'd10, 10'd20, 10'd120, 10'd40};
            2:       xs = '{10'd10, 10'd120, 10'd30, 10'd130};
            default: xs = '{10'd10, 10'd20, 10'd30, 10'd40};
        endcase
        for (int i = 0; i < N; i++) begin
            pipe_x_all[10*i +: 10]     = xs[i];
            pipe_y_top_all[10*i +: 10] = 10'd220;
            pipe_y_bot_all[10*i +: 10] = 10'd300;
        end
    endtask

    typedef struct {
        logic       rst, st, tk;
        int         pat;
        logic [3:0] valid;
        logic [1:0] e_state;
        logic       e_busy, e_done, e_over;
        logic [1:0] e_hit;
        logic [9:0] e_x;
    } vec_t;

    vec_t tbl [20];
    int   nscan;

    initial begin
        reset = 1'b0; start = 1'b0; frame_tick = 1'b0;
        pipe_valid = '0; pipe_x_all = '0; pipe_y_top_all = '0; pipe_y_bot_all = '0;

        //          rst st tk pat valid  state busy done over hit x
        tbl[0]  = '{1, 0, 0, 0, 4'hF,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 4'hF,   1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 4'hF,   1, 1, 0, 0, 0, 10};
        tbl[3]  = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 20};
        tbl[4]  = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 30};
        tbl[5]  = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 40};
        tbl[6]  = '{0, 0, 0, 0, 4'hF,   1, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 4'hF,   1, 1, 0, 0, 0, 10};
        tbl[8]  = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 20};
        tbl[9]  = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 30};
        tbl[10] = '{0, 0, 0, 0, 4'hF,   1, 1, 0, 0, 0, 40};
        tbl[11] = '{0, 0, 0, 0, 4'hF,   1, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 1, 4'hF,   1, 1, 0, 0, 0, 10};
        tbl[13] = '{0, 0, 0, 1, 4'hF,   1, 1, 0, 0, 0, 20};
        tbl[14] = '{0, 0, 0, 1, 4'hF,   1, 1, 0, 0, 0, 120};
        tbl[15] = '{0, 0, 0, 1, 4'hF,   1, 1, 0, 0, 0, 40};
        tbl[16] = '{0, 0, 0, 1, 4'hF,   2, 0, 1, 1, 2, 0};
        tbl[17] = '{0, 1, 0, 1, 4'hF,   0, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 1, 1, 0, 4'hF,   1, 0, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 4'hF,   1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            set_pat(tbl[i].pat);
            pipe_valid = tbl[i].valid;
            step(tbl[i].rst, tbl[i].st, tbl[i].tk);
            check("t_state", {30'd0, game_state}, {30'd0, tbl[i].e_state});
            check("t_busy", {31'd0, scan_busy}, {31'd0, tbl[i].e_busy});
            check("t_done", {31'd0, scan_done}, {31'd0, tbl[i].e_done});
            check("t_over", {31'd0, game_over}, {31'd0, tbl[i].e_over});
            check("t_hit", {30'd0, hit_pipe}, {30'd0, tbl[i].e_hit});
            check("t_chk_x", {22'd0, chk_pipe_x}, {22'd0, tbl[i].e_x});
        end

        // Live inputs and a stray tick mid-scan must not disturb the snapshot.
        set_pat(0);
        step(0, 0, 1);
        set_pat(1);
        step(0, 0, 1);
        check("h2_snap_x", {22'd0, chk_pipe_x}, 32'd20);
        check("h2_overrun", {31'd0, frame_overrun}, 32'd1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("h2_done_wait", {30'd0, game_state, scan_done}, 32'd3);
        check("h2_overrun_sticky", {31'd0, frame_overrun}, 32'd1);

        // Reset in the middle of a scan.
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        check("h3_state", {30'd0, game_state}, 32'd0);
        check("h3_busy_done", {30'd0, scan_busy, scan_done}, 32'd0);
        step(0, 0, 0);
        check("h3_no_done", {31'd0, scan_done}, 32'd0);

        // Hits on pipes 1 and 3 with pipe 1 invalid; invuln delays game over.
        step(0, 1, 0);
        set_pat(2);
        pipe_valid = 4'b1101;
        nscan = 0;
        for (int s = 0; s < 4; s++) begin
            if (!game_over) begin
                step(0, 0, 1);
                check("h1_invuln", {31'd0, invuln}, {31'd0, INV_EN && s < INV});
                repeat (4) step(0, 0, 0);
                nscan++;
            end
        end
        check("h1_game_over", {31'd0, game_over}, 32'd1);
        check("h1_hit_pipe", {30'd0, hit_pipe}, 32'd3);
        check("h1_scans", nscan, INV_EN ? 32'd3 : 32'd1);
        step(0, 1, 0);
        check("h1_restart", {29'd0, game_state, game_over, hit_pipe == 2'd0}, 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            pipe_valid = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < N; i++) begin
                    logic [9:0] top;
                    top = 10'(150 + $urandom_range(0, 110));
                    pipe_x_all[10*i +: 10]     = 10'(60 + $urandom_range(0, 120));
                    pipe_y_top_all[10*i +: 10] = top;
                    pipe_y_bot_all[10*i +: 10] = top + 10'($urandom_range(0, 100));
                end
            end
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
